// File: rtl/mul_issue_sched_pkg.sv
// ---------------------------------------------------------------------------
// mul_sched_pkg
//   Shared types and default sizes for the multiplier issue scheduler.
//   - sched_state_t : scheduler FSM states (RUN / DRAIN / HALT)
//   - N_REQ_DEF     : default number of reservation-station requesters
//   - DW_DEF        : default operand width
//   - TW_DEF        : default physical-register / ROB-tag field width
// ---------------------------------------------------------------------------
package mul_sched_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT
    } sched_state_t;

    localparam int unsigned N_REQ_DEF = 2;
    localparam int unsigned DW_DEF    = 16;
    localparam int unsigned TW_DEF    = 5;

    // Next value of the two-stage in-flight tracker. flush empties the
    // pipe, freeze holds it, otherwise ops move one stage forward.
    function automatic logic [1:0] inflight_next(
        input logic [1:0] cur,
        input logic       flush,
        input logic       freeze,
        input logic       issue
    );
        logic [1:0] nxt;
        nxt = cur;
        if (flush) begin
            nxt = '0;
        end else if (!freeze) begin
            nxt = {cur[0], issue};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mul_issue_sched_if.sv
// ---------------------------------------------------------------------------
// mul_issue_sched_if
//   Request/issue bundle between the reservation-station ports and the
//   multiplier issue scheduler.
//   Request side (per requester, slice i at [i*W +: W]):
//     req_valid, req_Pw, req_tag_ROB, req_busA, req_busB  -> scheduler
//     req_ready (one-hot grant)                           <- scheduler
//   Issue side (towards the multiplier):
//     valid_mul, Pw_mul, tag_ROB_mul, busA_mul, busB_mul  <- scheduler
//   Modports:
//     master : requesters / environment
//     slave  : the scheduler
// ---------------------------------------------------------------------------
interface mul_issue_sched_if
    import mul_sched_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned TW    = TW_DEF
);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*TW-1:0] req_Pw;
    logic [N_REQ*TW-1:0] req_tag_ROB;
    logic [N_REQ*DW-1:0] req_busA;
    logic [N_REQ*DW-1:0] req_busB;
    logic [N_REQ-1:0]    req_ready;

    logic                valid_mul;
    logic [TW-1:0]       Pw_mul;
    logic [TW-1:0]       tag_ROB_mul;
    logic [DW-1:0]       busA_mul;
    logic [DW-1:0]       busB_mul;

    modport master (
        output req_valid,
        output req_Pw,
        output req_tag_ROB,
        output req_busA,
        output req_busB,
        input  req_ready,
        input  valid_mul,
        input  Pw_mul,
        input  tag_ROB_mul,
        input  busA_mul,
        input  busB_mul
    );

    modport slave (
        input  req_valid,
        input  req_Pw,
        input  req_tag_ROB,
        input  req_busA,
        input  req_busB,
        output req_ready,
        output valid_mul,
        output Pw_mul,
        output tag_ROB_mul,
        output busA_mul,
        output busB_mul
    );

endinterface

// File: rtl/mul_issue_sched_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin picker.
//   Ports:
//     req   in  N_REQ  request vector
//     ptr   in  PW     highest-priority requester index
//     en    in  1      grant enable; no grant when low
//     grant out N_REQ  one-hot grant (all zero when nothing granted)
//     idx   out PW     encoded index of the granted requester (0 if none)
//   Search order is ptr, ptr+1, ... modulo N_REQ.
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned PW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    idx
);

    logic          found;
    logic [PW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = PW'((32'(ptr) + k) % N_REQ);
            if (en && !found && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_issue_sched.sv
// ---------------------------------------------------------------------------
// mul_issue_sched
//   Issue scheduler for the shared two-stage pipelined multiplier. Grants at
//   most one requester per cycle (round robin), drives the multiplier issue
//   port, mirrors the multiplier pipeline occupancy and supports draining.
//   Ports:
//     clk          in   clock, rising edge
//     rst          in   asynchronous active-low reset
//     flush        in   pipeline flush (as seen by the multiplier)
//     freeze_back  in   back-end freeze (as seen by the multiplier)
//     bus          slave request / issue bundle (mul_issue_sched_if)
//     drain_req    in   level request to stop issuing
//     drain_done   out  high while in HALT
//     inflight     out  bit0 = op in stage 1, bit1 = op on result register
//     issue_cnt    out  wrapping count of accepted issues
// ---------------------------------------------------------------------------
module mul_issue_sched
    import mul_sched_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned TW    = TW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                freeze_back,
    mul_issue_sched_if.slave    bus,
    input  logic                drain_req,
    output logic                drain_done,
    output logic [1:0]          inflight,
    output logic [15:0]         issue_cnt
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    sched_state_t     state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [1:0]       inflight_q, inflight_d;
    logic [15:0]      issue_cnt_q, issue_cnt_d;

    logic             can_issue;
    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    grant_idx;
    logic             valid_mul;

    logic [TW-1:0]    pw_mux;
    logic [TW-1:0]    tag_mux;
    logic [DW-1:0]    busa_mux;
    logic [DW-1:0]    busb_mux;

    // rst is folded in so nothing is granted while reset is held low,
    // not just after the flops have cleared.
    assign can_issue = rst && (state_q == RUN) && !flush && !freeze_back;

    rr_picker #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_picker (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .en    (can_issue),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign valid_mul = |grant;

    // Output mux: fields are forced to zero when nothing is issued.
    always_comb begin
        pw_mux   = '0;
        tag_mux  = '0;
        busa_mux = '0;
        busb_mux = '0;
        if (valid_mul) begin
            pw_mux   = bus.req_Pw     [32'(grant_idx) * TW +: TW];
            tag_mux  = bus.req_tag_ROB[32'(grant_idx) * TW +: TW];
            busa_mux = bus.req_busA   [32'(grant_idx) * DW +: DW];
            busb_mux = bus.req_busB   [32'(grant_idx) * DW +: DW];
        end
    end

    assign bus.req_ready   = grant;
    assign bus.valid_mul   = valid_mul;
    assign bus.Pw_mul      = pw_mux;
    assign bus.tag_ROB_mul = tag_mux;
    assign bus.busA_mul    = busa_mux;
    assign bus.busB_mul    = busb_mux;

    // Round-robin pointer: moves past the winner, holds otherwise.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (valid_mul) begin
            if (grant_idx == PW'(N_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + 1'b1;
            end
        end
    end

    always_comb begin
        inflight_d  = inflight_next(inflight_q, flush, freeze_back, valid_mul);
        issue_cnt_d = issue_cnt_q + (valid_mul ? 16'd1 : 16'd0);
    end

    // FSM. DRAIN never issues (can_issue needs RUN), so "not issuing" in
    // the DRAIN->HALT condition reduces to an empty in-flight tracker.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!drain_req) begin
                    state_d = RUN;
                end else if ((inflight_q == 2'b00) && !valid_mul) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (!drain_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            rr_ptr_q    <= '0;
            inflight_q  <= '0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            inflight_q  <= inflight_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign drain_done = (state_q == HALT);
    assign inflight   = inflight_q;
    assign issue_cnt  = issue_cnt_q;

endmodule
